if_stage: RTL

- Instruction-fetch stage of the 5-stage pipeline CPU.
- It is the initiator on the instruction-memory interface: it owns the PC register, drives the fetch address to the combinational instruction ROM, and captures the returned word.
- It registers the fetched word, the PC, PC+8 and fault status into the F/D pipeline register for the decode stage.
- Branch and jump redirects arrive from decode; the architecture uses one delay slot.

---
 rtl/cpu_defs_pkg.sv | 20 ++
 rtl/if_stage_fd_reg.sv | 38 +++
 rtl/if_stage.sv | 70 +++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU constants and the F/D pipeline record.
// No logic here. It carries the reset PC, the ROM window, the nop encoding and the link offset.
// It is used by fetch, the ROM, decode and exception handling.
package cpu_defs;

    localparam logic [31:0] PC_RESET     = 32'h0000_3000;
    localparam int          IM_WORDS     = 4096;
    localparam logic [31:0] IM_LAST_ADDR = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;
    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] LINK_OFFSET  = 32'd8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        valid;
        logic        adel;
    } fd_t;

endpackage

// File: rtl/if_stage_fd_reg.sv
// F/D pipeline register: instr, pc, pc8, valid and adel.
// Latency is 1 cycle. A clear loads a bubble and wins over a held enable.
// Backpressure: when en is low the register holds its contents.
module fd_reg
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc8_f,
    input  logic        fault_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        adel_d
);

    fd_t fd_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            fd_q <= '0;
        end else if (en) begin
            fd_q <= '{instr: instr_f, pc: pc_f, pc8: pc8_f, valid: 1'b1, adel: fault_f};
        end
    end

    assign instr_d = fd_q.instr;
    assign pc_d    = fd_q.pc;
    assign pc8_d   = fd_q.pc8;
    assign valid_d = fd_q.valid;
    assign adel_d  = fd_q.adel;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: holds the PC, addresses the ROM and fills the F/D register.
// Latency is 1 cycle from pc_f to instr_d. Redirects take effect on the next edge and keep the delay slot.
// Backpressure: stall freezes both the PC and F/D, and fd_clr injects a bubble.
module if_stage
#(
    parameter logic [31:0] PC_RESET = cpu_defs::PC_RESET,
    parameter int          IM_WORDS = cpu_defs::IM_WORDS
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        fd_clr,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        adel_d
);
    import cpu_defs::*;

    localparam logic [31:0] LAST_ADDR = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

    logic        fault_f;
    logic [31:0] instr_f;
    logic [31:0] pc_next;

    // Addresses that are misaligned or outside the ROM window fetch a nop and are flagged.
    assign fault_f = (pc_f[1:0] != 2'b00) || (pc_f < PC_RESET) || (pc_f > LAST_ADDR);
    assign instr_f = fault_f ? NOP : im_instr;
    assign im_pc   = pc_f;

    always_comb begin
        pc_next = pc_f + 32'd4;
        if (redirect_en) begin
            pc_next = redirect_pc;
        end
    end

    // Decode holds a redirect across a stall, so ignoring it here loses nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f <= PC_RESET;
        end else if (!stall) begin
            pc_f <= pc_next;
        end
    end

    fd_reg u_fd_reg (
        .clk     (clk),
        .reset   (reset),
        .clr     (fd_clr),
        .en      (!stall),
        .instr_f (instr_f),
        .pc_f    (pc_f),
        .pc8_f   (pc_f + LINK_OFFSET),
        .fault_f (fault_f),
        .instr_d (instr_d),
        .pc_d    (pc_d),
        .pc8_d   (pc8_d),
        .valid_d (valid_d),
        .adel_d  (adel_d)
    );

endmodule
